// File: rtl/pipe_reg_skid.sv
// Purpose: pipeline-stage register with a 2-entry skid buffer, flush and stall/flush counters.
// Latency: 1 cycle from push to out_* when empty; otherwise strict FIFO order behind held entries.
// Backpressure: in_ready is a pure decode of registered state (low only when both entries are held).
module pipe_reg_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                push;
  logic                pop;

  // Status decode from the state register only; an illegal encoding looks empty.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Bubbles must never carry live write enables downstream.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Next-state, payload movement and saturating counters; flush overrides any transfer.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (flush) begin
      // Payload registers keep their contents; only the occupancy is dropped.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_ONE: begin
          if (push && !pop) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end
        end
        default: begin
          // EMPTY, and recovery path for an illegal encoding.
          state_d = ST_EMPTY;
          if (push) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end
        end
      endcase
    end

    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (occupancy != 2'd0) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, payload and counter registers; reset clears everything at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Next-generation parametrised pipeline register for the MIPS pipeline stage boundaries (F/D, D/E, E/M, M/W).
- Replaces the free-running per-signal buffers with one packed payload, a valid/ready handshake and a 2-entry skid buffer, so back-pressure stalls do not need combinational ready paths.
- Adds synchronous flush for bubble insertion, control-field zeroing on bubbles, and saturating stall/flush performance counters.

Parameters:
DATA_W, 32, width of the data payload (e.g. ALUOut, WriteData, PC+8 packed by the instantiating stage)
CTRL_W, 8, width of the control payload (RegWrite, MemWrite, etc.); forced to zero whenever out_valid=0
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  upstream stage presents a payload
in_ready  out  1  block can accept; registered, depends only on state
in_ctrl  in  CTRL_W  upstream control payload
in_data  in  DATA_W  upstream data payload
out_valid  out  1  main entry holds a valid payload
out_ready  in  1  downstream stage consumes this cycle
out_ctrl  out  CTRL_W  control payload of main entry; 0 when out_valid=0
out_data  out  DATA_W  data payload of main entry
occupancy  out  2  number of held entries (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
flush_cnt  out  CNT_W  flush cycles that discarded at least one entry, saturating

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each ctrl+data. State machine EMPTY / ONE / FULL.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY). occupancy = 0 / 1 / 2 for EMPTY / ONE / FULL.
- Latency: payload pushed at edge N is on out_* after edge N when the block was EMPTY, or after the pop that promotes it. Strict FIFO order.
- EMPTY: push -> main<=in, go to ONE.
- ONE, push & !pop -> skid<=in, go to FULL.
- ONE, push & pop -> main<=in, stay in ONE.
- ONE, !push & pop -> go to EMPTY.
- ONE, no push and no pop -> hold.
- FULL: push impossible. pop -> main<=skid, go to ONE. No pop -> hold.
- Flush has priority over everything:
  - state<=EMPTY.
  - Any push in the same cycle is dropped.
  - A pop in the same cycle is still seen downstream, because the outputs are valid before the edge.
  - out_data is not cleared.
- Bubble rule: out_ctrl = out_valid ? main_ctrl : 0, so a stale payload can never assert a write enable.
- stall_cnt: +1 each cycle with out_valid & !out_ready, including flush cycles. Holds at 2^CNT_W-1.
- flush_cnt: +1 on flush when occupancy != 0. Holds at max.
- Reset (RST_N=0, asynchronous):
  - State, payload registers and counters clear immediately.
  - Outputs: in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, flush_cnt=0.
  - Reset mid-transfer discards all entries with no partial update.
  - Release is synchronous to CLK at the first rising edge after RST_N=1.
- Unknown state encodings recover to EMPTY.

Test Plan:
- Reset: assert RST_N=0 between edges -> out_valid=0, in_ready=1, occupancy=0, counters=0 before the next CLK edge.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, occupancy stays 1, in_ready stays 1, stall_cnt=0.
- Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, 0xC held off upstream. Raise out_ready -> 0xA, then 0xB, then 0xC in order. stall_cnt equals the number of cycles out_ready was low with out_valid=1.
- Flush when FULL with in_valid=1 (in_ctrl=0xFF) -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, flush_cnt=1, flushed input never appears. Flush when EMPTY -> flush_cnt unchanged.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Reset mid-operation: FULL state, pulse RST_N low -> occupancy=0 immediately. After release, push 0x5 -> 0x5 out next cycle, no stale skid data.
